// File: rtl/game_pkg.sv
// Shared constants for the game session controller: audio sample map, FSM encoding, BCD digit width.
package game_pkg;

  localparam int BCD_W = 4;

  localparam logic [3:0] SAMPLE_WALLS      = 4'd1;
  localparam logic [3:0] SAMPLE_PADDLE     = 4'd2;
  localparam logic [3:0] SAMPLE_LOST_BALL  = 4'd3;
  localparam logic [3:0] SAMPLE_BLOCK_BASE = 4'd8;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  typedef struct packed {
    logic       lost;
    logic       block;
    logic       paddle;
    logic       wall;
    logic [2:0] row;
  } step_ev_t;

  typedef struct packed {
    logic       trig;
    logic [3:0] sel;
  } audio_t;

  // Highest-priority sound for one physics step; trig=0 when nothing audible happened.
  function automatic audio_t audio_pick(input step_ev_t ev);
    audio_t a;
    a.trig = 1'b1;
    if (ev.lost)        a.sel = SAMPLE_LOST_BALL;
    else if (ev.block)  a.sel = SAMPLE_BLOCK_BASE + {1'b0, ev.row};
    else if (ev.paddle) a.sel = SAMPLE_PADDLE;
    else if (ev.wall)   a.sel = SAMPLE_WALLS;
    else begin
      a.trig = 1'b0;
      a.sel  = '0;
    end
    return a;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal score digit: counts 0..9 when enabled, carry out on 9->0, hold freezes the chain at all-nines.
module bcd_digit
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             hold,
  output logic [BCD_W-1:0] digit,
  output logic             co
);

  logic [BCD_W-1:0] digit_q, digit_d;
  logic             wrap;

  assign wrap = (digit_q == BCD_W'(9));

  always_comb begin
    digit_d = digit_q;
    if (clr)             digit_d = '0;
    else if (en && !hold) digit_d = wrap ? '0 : digit_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign co    = en & ~hold & wrap;

endmodule

// File: rtl/game_session_ctrl.sv
// Game session sequencer: level/lives FSM, prioritized audio cue, paced BCD score with high score.
// Optional GAME_SESSION_CTRL_EXTRA_LIFE_EN: +1 life on every thousand points, capped at MAX_LIVES.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int START_LIVES = 5,
  parameter int MAX_LIVES   = 7,
  parameter int LEVELS      = 4,
  parameter int ROWS        = 5,
  parameter int PEND_W      = 6
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         STEP_COMPLETE,
  input  logic                                         BALL_LOST,
  input  logic                                         HIT_BLOCK,
  input  logic                                         HIT_PADDLE,
  input  logic                                         HIT_WALL,
  input  logic                                         BLOCKS_CLEARED,
  input  logic [2:0]                                   HIT_BLOCK_ROW,
  input  logic                                         PAUSE,
  input  logic                                         START,
  output logic [3:0]                                   AUDIO_SELECT,
  output logic                                         AUDIO_TRIGGER,
  output logic                                         RUN_ENABLE,
  output logic                                         LOAD_LEVEL,
  output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] LEVEL,
  output logic [$clog2(MAX_LIVES+1)-1:0]               LIVES,
  output logic                                         GAME_OVER,
  output logic [4*DIGITS-1:0]                          SCORE,
  output logic [4*DIGITS-1:0]                          HIGH_SCORE
);

  localparam int LW  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int LVW = $clog2(MAX_LIVES+1);
  localparam int SW  = BCD_W * DIGITS;
  localparam int AW  = PEND_W + 8;

  localparam logic [LW-1:0]     LEVEL_LAST  = LW'(LEVELS - 1);
  localparam logic [LVW-1:0]    LIVES_START = LVW'(START_LIVES);
  localparam logic [PEND_W-1:0] PEND_MAX    = '1;
  localparam logic [SW-1:0]     ALL_NINES   = {DIGITS{4'h9}};

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LVW-1:0]    lives_q, lives_d;
  logic [SW-1:0]     hi_q, hi_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        aud_sel_q, aud_sel_d;
  logic              aud_trig_q, aud_trig_d;

  step_ev_t          ev;
  audio_t            aud;
  logic              step, lost, clear, restart, drain, go_over;
  logic              grant, lives_room;
  logic [7:0]        row_ext, weight;
  logic [AW-1:0]     sum;

  logic [SW-1:0]     score;
  logic [DIGITS-1:0] dig_en, score_co;
  logic              all9;
  logic              unused_co;

  assign ev = '{lost: BALL_LOST, block: HIT_BLOCK, paddle: HIT_PADDLE,
                wall: HIT_WALL, row: HIT_BLOCK_ROW};

  assign step    = STEP_COMPLETE & (state_q == ST_PLAY);
  assign lost    = step & BALL_LOST;
  assign clear   = step & BLOCKS_CLEARED;
  assign restart = (state_q == ST_OVER) & START;
  assign drain   = (pend_q != '0);
  assign all9    = (score == ALL_NINES);

`ifdef GAME_SESSION_CTRL_EXTRA_LIFE_EN
  localparam logic [LVW-1:0] LIVES_MAX = LVW'(MAX_LIVES);
  // Carry out of the hundreds digit marks each thousand-point boundary.
  if (DIGITS > 2) begin : g_grant
    assign grant = score_co[2];
  end else begin : g_no_grant
    assign grant = 1'b0;
  end
  assign lives_room = (lives_q != LIVES_MAX);
`else
  assign grant      = 1'b0;
  assign lives_room = 1'b0;
`endif

  always_comb begin
    aud        = audio_pick(ev);
    aud_trig_d = step & aud.trig;
    aud_sel_d  = (step & aud.trig) ? aud.sel : aud_sel_q;

    row_ext = 8'(HIT_BLOCK_ROW);
    weight  = (row_ext < 8'(ROWS)) ? 8'(ROWS) - row_ext : 8'd0;
    if (!(step && HIT_BLOCK)) weight = 8'd0;

    // Add and drain in one sum so a coinciding hit loses nothing but the single drained point.
    sum    = AW'(pend_q) + AW'(weight) - AW'(drain);
    pend_d = (sum > AW'(PEND_MAX)) ? PEND_MAX : sum[PEND_W-1:0];
    if (restart) pend_d = '0;

    lives_d = lives_q;
    go_over = 1'b0;
    if (lost && !grant) begin
      if (lives_q != '0) lives_d = lives_q - 1'b1;
      go_over = (lives_q <= LVW'(1));
    end else if (grant && !lost && lives_room) begin
      lives_d = lives_q + 1'b1;
    end
    if (restart) lives_d = LIVES_START;

    state_d = state_q;
    level_d = level_q;
    hi_d    = hi_q;
    case (state_q)
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        if (go_over) begin
          state_d = ST_OVER;
          // Valid packed BCD orders the same as unsigned binary.
          if (score > hi_q) hi_d = score;
        end else if (clear) begin
          state_d = ST_LOAD;
          level_d = (level_q == LEVEL_LAST) ? '0 : level_q + 1'b1;
        end
      end
      ST_OVER: begin
        if (START) begin
          state_d = ST_LOAD;
          level_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_LOAD;
      level_q    <= '0;
      lives_q    <= LIVES_START;
      hi_q       <= '0;
      pend_q     <= '0;
      aud_sel_q  <= '0;
      aud_trig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      hi_q       <= hi_d;
      pend_q     <= pend_d;
      aud_sel_q  <= aud_sel_d;
      aud_trig_q <= aud_trig_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign dig_en[i] = drain;
    end else begin : g_upper
      assign dig_en[i] = score_co[i-1];
    end
    bcd_digit u_dig (
      .clk   (CLK),
      .rst   (RESET),
      .clr   (restart),
      .en    (dig_en[i]),
      .hold  (all9),
      .digit (score[i*BCD_W +: BCD_W]),
      .co    (score_co[i])
    );
  end

  assign unused_co = score_co[DIGITS-1];

  assign AUDIO_SELECT  = aud_sel_q;
  assign AUDIO_TRIGGER = aud_trig_q;
  assign RUN_ENABLE    = (state_q == ST_PLAY) & ~PAUSE;
  assign LOAD_LEVEL    = (state_q == ST_LOAD);
  assign GAME_OVER     = (state_q == ST_OVER);
  assign LEVEL         = level_q;
  assign LIVES         = lives_q;
  assign SCORE         = score;
  assign HIGH_SCORE    = hi_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl: stimulus pushes expected audio/load/over events, a monitor pops them.
module tb_game_session_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        RESET, STEP_COMPLETE, BALL_LOST, HIT_BLOCK, HIT_PADDLE, HIT_WALL, BLOCKS_CLEARED;
  logic [2:0]  HIT_BLOCK_ROW;
  logic        PAUSE, START;
  logic [3:0]  AUDIO_SELECT;
  logic        AUDIO_TRIGGER, RUN_ENABLE, LOAD_LEVEL, GAME_OVER;
  logic [1:0]  LEVEL;
  logic [2:0]  LIVES;
  logic [15:0] SCORE, HIGH_SCORE;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  aud_q[$];
  logic [1:0]  load_q[$];
  logic [15:0] over_q[$];
  logic        prev_load = 1'b0;
  logic        prev_over = 1'b0;

  localparam logic [4:0] E_LOST = 5'b10000, E_BLK = 5'b01000, E_PAD = 5'b00100,
                         E_WALL = 5'b00010, E_CLR = 5'b00001;

`ifdef GAME_SESSION_CTRL_EXTRA_LIFE_EN
  localparam int LIVES_AT_1000 = 6;
  localparam int LIVES_FINAL   = 7;
`else
  localparam int LIVES_AT_1000 = 5;
  localparam int LIVES_FINAL   = 5;
`endif

  game_session_ctrl dut (
    .CLK(clk), .RESET(RESET), .STEP_COMPLETE(STEP_COMPLETE), .BALL_LOST(BALL_LOST),
    .HIT_BLOCK(HIT_BLOCK), .HIT_PADDLE(HIT_PADDLE), .HIT_WALL(HIT_WALL),
    .BLOCKS_CLEARED(BLOCKS_CLEARED), .HIT_BLOCK_ROW(HIT_BLOCK_ROW), .PAUSE(PAUSE),
    .START(START), .AUDIO_SELECT(AUDIO_SELECT), .AUDIO_TRIGGER(AUDIO_TRIGGER),
    .RUN_ENABLE(RUN_ENABLE), .LOAD_LEVEL(LOAD_LEVEL), .LEVEL(LEVEL), .LIVES(LIVES),
    .GAME_OVER(GAME_OVER), .SCORE(SCORE), .HIGH_SCORE(HIGH_SCORE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One step sampled at the next rising edge; returns just after that edge.
  task automatic step(input logic [4:0] ev, input logic [2:0] row);
    STEP_COMPLETE = 1'b1;
    {BALL_LOST, HIT_BLOCK, HIT_PADDLE, HIT_WALL, BLOCKS_CLEARED} = ev;
    HIT_BLOCK_ROW = row;
    cycles(1);
    STEP_COMPLETE = 1'b0;
    {BALL_LOST, HIT_BLOCK, HIT_PADDLE, HIT_WALL, BLOCKS_CLEARED} = '0;
    HIT_BLOCK_ROW = '0;
  endtask

  task automatic hit(input logic [2:0] row, input logic [3:0] exp_sel);
    aud_q.push_back(exp_sel);
    step(E_BLK, row);
  endtask

  task automatic lose(input logic [4:0] extra);
    aud_q.push_back(SAMPLE_LOST_BALL);
    step(E_LOST | extra, 3'd0);
  endtask

  task automatic restart();
    load_q.push_back(2'd0);
    START = 1'b1;
    cycles(1);
    START = 1'b0;
  endtask

  always @(negedge clk) begin
    if (RESET) begin
      prev_load <= 1'b0;
      prev_over <= 1'b0;
    end else begin
      if (AUDIO_TRIGGER) begin
        if (aud_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL audio_unexpected: trigger with select %h, none expected", AUDIO_SELECT);
        end else chk("audio_select", 32'(AUDIO_SELECT), 32'(aud_q.pop_front()));
      end
      if (LOAD_LEVEL) begin
        chk("load_pulse_width", 32'(prev_load), 32'd0);
        if (load_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL load_unexpected: LOAD_LEVEL at level %0d, none expected", LEVEL);
        end else chk("load_level", 32'(LEVEL), 32'(load_q.pop_front()));
      end
      if (GAME_OVER && !prev_over) begin
        if (over_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL over_unexpected: GAME_OVER with high %h, none expected", HIGH_SCORE);
        end else chk("over_high_score", 32'(HIGH_SCORE), 32'(over_q.pop_front()));
      end
      prev_load <= LOAD_LEVEL;
      prev_over <= GAME_OVER;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; STEP_COMPLETE = 1'b0; BALL_LOST = 1'b0; HIT_BLOCK = 1'b0; HIT_PADDLE = 1'b0;
    HIT_WALL = 1'b0; BLOCKS_CLEARED = 1'b0; HIT_BLOCK_ROW = '0; PAUSE = 1'b0; START = 1'b0;
    cycles(2);
    chk("rst_score", 32'(SCORE), 32'h0);
    chk("rst_lives", 32'(LIVES), 32'd5);
    chk("rst_trigger", 32'(AUDIO_TRIGGER), 32'd0);
    chk("rst_select", 32'(AUDIO_SELECT), 32'd0);
    chk("rst_run", 32'(RUN_ENABLE), 32'd0);
    chk("rst_over", 32'(GAME_OVER), 32'd0);

    load_q.push_back(2'd0);
    RESET = 1'b0;
    chk("load_cycle_run", 32'(RUN_ENABLE), 32'd0);
    cycles(1);
    chk("play_run", 32'(RUN_ENABLE), 32'd1);
    chk("play_load", 32'(LOAD_LEVEL), 32'd0);
    chk("play_lives", 32'(LIVES), 32'd5);
    chk("play_score", 32'(SCORE), 32'h0);
    chk("play_level", 32'(LEVEL), 32'd0);
    PAUSE = 1'b1; #1;
    chk("pause_run", 32'(RUN_ENABLE), 32'd0);
    PAUSE = 1'b0; #1;
    chk("unpause_run", 32'(RUN_ENABLE), 32'd1);

    // Block row 0 with wall in the same step: block wins, 5 points paced over 5 cycles.
    aud_q.push_back(SAMPLE_BLOCK_BASE);
    step(E_BLK | E_WALL, 3'd0);
    cycles(4);
    chk("drain_4", 32'(SCORE), 32'h0004);
    cycles(1);
    chk("drain_5", 32'(SCORE), 32'h0005);
    cycles(3);
    chk("drain_hold", 32'(SCORE), 32'h0005);

    hit(3'd0, SAMPLE_BLOCK_BASE);
    hit(3'd0, SAMPLE_BLOCK_BASE);
    cycles(15);
    chk("two_hits", 32'(SCORE), 32'h0015);

    aud_q.push_back(SAMPLE_PADDLE);
    step(E_PAD | E_WALL, 3'd0);
    aud_q.push_back(SAMPLE_WALLS);
    step(E_WALL, 3'd0);
    step(5'd0, 3'd0);
    HIT_WALL = 1'b1; cycles(1); HIT_WALL = 1'b0;
    hit(3'd3, 4'd11);
    cycles(6);
    chk("row3_weight", 32'(SCORE), 32'h0017);

    for (int i = 1; i <= 4; i++) begin
      load_q.push_back(2'(i % 4));
      step(E_CLR, 3'd0);
      if (i == 4) step(E_CLR | E_WALL | E_BLK, 3'd0);
      else cycles(1);
    end
    chk("level_wrap", 32'(LEVEL), 32'd0);
    cycles(6);
    chk("load_step_ignored", 32'(SCORE), 32'h0017);

    for (int i = 0; i < 5; i++) begin
      if (i == 4) over_q.push_back(16'h0017);
      lose(5'd0);
    end
    chk("over_lives", 32'(LIVES), 32'd0);
    chk("over_flag", 32'(GAME_OVER), 32'd1);
    chk("over_run", 32'(RUN_ENABLE), 32'd0);
    chk("over_high", 32'(HIGH_SCORE), 32'h0017);
    step(E_WALL | E_BLK, 3'd0);
    cycles(3);
    chk("over_step_ignored", 32'(SCORE), 32'h0017);
    restart();
    chk("restart_lives", 32'(LIVES), 32'd5);
    chk("restart_score", 32'(SCORE), 32'h0);
    chk("restart_high", 32'(HIGH_SCORE), 32'h0017);
    chk("restart_over", 32'(GAME_OVER), 32'd0);
    cycles(1);

    load_q.push_back(2'd1);
    step(E_CLR, 3'd0);
    cycles(1);
    for (int i = 0; i < 4; i++) lose(5'd0);
    chk("lives_one", 32'(LIVES), 32'd1);
    over_q.push_back(16'h0017);
    lose(E_CLR);
    chk("both_over", 32'(GAME_OVER), 32'd1);
    chk("both_level", 32'(LEVEL), 32'd1);
    chk("both_no_load", 32'(LOAD_LEVEL), 32'd0);
    restart();
    chk("restart2_level", 32'(LEVEL), 32'd0);
    cycles(1);

    // 20 back-to-back hits: pending clips at 63, so 82 points rather than 100.
    for (int i = 0; i < 20; i++) hit(3'd0, SAMPLE_BLOCK_BASE);
    cycles(70);
    chk("pend_saturate", 32'(SCORE), 32'h0082);

    for (int i = 0; i < 183; i++) begin hit(3'd0, SAMPLE_BLOCK_BASE); cycles(4); end
    hit(3'd4, 4'd12);
    cycles(4);
    chk("score_998", 32'(SCORE), 32'h0998);
    chk("lives_998", 32'(LIVES), 32'd5);
    hit(3'd0, SAMPLE_BLOCK_BASE);
    cycles(6);
    chk("score_1003", 32'(SCORE), 32'h1003);
    chk("lives_1000", 32'(LIVES), 32'(LIVES_AT_1000));

    for (int i = 0; i < 1800; i++) begin hit(3'd0, SAMPLE_BLOCK_BASE); cycles(4); end
    cycles(8);
    chk("score_hold_9999", 32'(SCORE), 32'h9999);
    chk("lives_final", 32'(LIVES), 32'(LIVES_FINAL));

    for (int i = 0; i < LIVES_FINAL; i++) begin
      if (i == LIVES_FINAL - 1) over_q.push_back(16'h9999);
      lose(5'd0);
    end
    chk("final_high", 32'(HIGH_SCORE), 32'h9999);
    chk("final_over", 32'(GAME_OVER), 32'd1);

    cycles(3);
    chk("aud_q_drained", 32'(aud_q.size()), 32'd0);
    chk("load_q_drained", 32'(load_q.size()), 32'd0);
    chk("over_q_drained", 32'(over_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
